// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller slice: state encoding
// and default sizing for the receive FIFO and error counter.
package uart_pkg;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ERR_CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CLEAR = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead byte FIFO: head is always visible on rd_data (0 when
// empty); a push into a full FIFO is accepted only if a pop happens alongside.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop && !w_empty;
  // When full, the slot being written is the head being popped this same cycle.
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the UART receiver: arms it, harvests each frame into the receive
// FIFO, tracks overrun/framing status, and clears the receiver after every frame.
//
// state | meaning
// IDLE  | receive path disabled, receiver held off
// CLEAR | one-cycle synchronous clear of the receiver's sticky flags
// WAIT  | receiver armed, waiting for done/err or disable
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ERR_CNT_W  = ERR_CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          enable,
  input  logic                          clr_status,
  input  logic                          rd_en,
  input  logic                          rx_busy,
  input  logic                          rx_done,
  input  logic                          rx_err,
  input  logic [7:0]                    rx_data,
  output logic                          rx_en,
  output logic                          rx_rst,
  output logic [7:0]                    rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic                          ctrl_busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  rx_state_e            r_state;
  logic                 r_rx_en;
  logic                 r_rx_rst;
  logic                 r_busy;
  logic                 r_overrun;
  logic                 r_frame_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic w_in_wait;
  logic w_err_evt;
  logic w_done_evt;
  logic w_push;
  logic w_drop;
  logic w_fifo_full;
  logic w_unused;

  // Aborts are driven by enable alone; receiver busy is informational here.
  assign w_unused = rx_busy;

  assign w_in_wait  = (r_state == WAIT);
  assign w_err_evt  = w_in_wait && enable && rx_err;
  assign w_done_evt = w_in_wait && enable && !rx_err && rx_done;
  assign w_push     = w_done_evt && (!w_fifo_full || rd_en);
  assign w_drop     = w_done_evt && w_fifo_full && !rd_en;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= IDLE;
      r_rx_en  <= 1'b0;
      r_rx_rst <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state  <= CLEAR;
            r_rx_rst <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        CLEAR: begin
          r_rx_rst <= 1'b0;
          if (enable) begin
            r_state <= WAIT;
            r_rx_en <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (!enable || rx_err || rx_done) begin
            r_state  <= CLEAR;
            r_rx_en  <= 1'b0;
            r_rx_rst <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rx_en  <= 1'b0;
          r_rx_rst <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // A new event in the same cycle as clr_status takes precedence over the clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_drop)          r_overrun <= 1'b1;
      else if (clr_status) r_overrun <= 1'b0;

      if (w_err_evt) begin
        r_frame_err <= 1'b1;
        if (clr_status)                  r_err_count <= ERR_CNT_W'(1);
        else if (r_err_count != ERR_MAX) r_err_count <= r_err_count + ERR_CNT_W'(1);
      end else if (clr_status) begin
        r_frame_err <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .push    (w_push),
    .pop     (rd_en),
    .wr_data (rx_data),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (w_fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_full = w_fifo_full;
  assign rx_en     = r_rx_en;
  assign rx_rst    = r_rx_rst;
  assign ctrl_busy = r_busy;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-based reference model.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       enable, clr_status, rd_en, rx_busy, rx_done, rx_err;
  logic [7:0] rx_data;
  logic       rx_en, rx_rst, fifo_empty, fifo_full, overrun, frame_err, ctrl_busy;
  logic [7:0] rd_data;
  logic [2:0] fifo_count;
  logic [7:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .clr_status(clr_status),
    .rd_en(rd_en), .rx_busy(rx_busy), .rx_done(rx_done), .rx_err(rx_err),
    .rx_data(rx_data), .rx_en(rx_en), .rx_rst(rx_rst), .rd_data(rd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .overrun(overrun), .frame_err(frame_err), .err_count(err_count),
    .ctrl_busy(ctrl_busy)
  );

  typedef struct {
    bit en, done, err, rd, clr;
    logic [7:0] data;
    bit x_en, x_rst;
    int x_cnt;
    logic [7:0] x_rd;
    bit x_ovr, x_fe;
    int x_ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit done, bit err, bit rd, bit clr, logic [7:0] data,
                              bit x_en, bit x_rst, int x_cnt, logic [7:0] x_rd,
                              bit x_ovr, bit x_fe, int x_ec);
    vec_t v;
    v.en = en; v.done = done; v.err = err; v.rd = rd; v.clr = clr; v.data = data;
    v.x_en = x_en; v.x_rst = x_rst; v.x_cnt = x_cnt; v.x_rd = x_rd;
    v.x_ovr = x_ovr; v.x_fe = x_fe; v.x_ec = x_ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    clr_status = 0; rd_en = 0; rx_done = 0; rx_err = 0; rx_busy = 0;
  endtask

  task automatic frame(input logic [7:0] d);
    rx_done = 1; rx_data = d; cyc();
    rx_done = 0; cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rx_en"}, rx_en, 0);
    chk({tag, " rx_rst"}, rx_rst, 0);
    chk({tag, " ctrl_busy"}, ctrl_busy, 0);
    chk({tag, " overrun"}, overrun, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " err_count"}, err_count, 0);
    chk({tag, " fifo_count"}, fifo_count, 0);
    chk({tag, " fifo_empty"}, fifo_empty, 1);
    chk({tag, " fifo_full"}, fifo_full, 0);
    chk({tag, " rd_data"}, rd_data, 0);
  endtask

  // reference model state
  bit         m_armed, m_clearing, m_ovr, m_fe;
  int         m_ec;
  logic [7:0] m_q[$];

  initial begin
    arst_n = 0; enable = 0; rx_data = 0;
    idle_in();
    repeat (2) @(negedge clk);
    arst_n = 1;
    @(negedge clk);
    chk_reset_vals("reset");

    // enable, single frame, overrun fill, drain, status clear
    tbl.push_back(mk(1,0,0,0,0,8'h00, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,8'h00, 1,0,0,8'h00,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,8'hA5, 0,1,1,8'hA5,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,8'h00, 1,0,1,8'hA5,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,8'h00, 1,0,0,8'h00,0,0,0));
    for (int k = 1; k <= 4; k++) begin
      tbl.push_back(mk(1,1,0,0,0,8'(k), 0,1,k,8'h01,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,8'h00, 1,0,k,8'h01,0,0,0));
    end
    tbl.push_back(mk(1,1,0,0,0,8'h05, 0,1,4,8'h01,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,8'h00, 1,0,4,8'h01,1,0,0));
    tbl.push_back(mk(1,0,0,1,0,8'h00, 1,0,3,8'h02,1,0,0));
    tbl.push_back(mk(1,0,0,1,0,8'h00, 1,0,2,8'h03,1,0,0));
    tbl.push_back(mk(1,0,0,1,0,8'h00, 1,0,1,8'h04,1,0,0));
    tbl.push_back(mk(1,0,0,1,0,8'h00, 1,0,0,8'h00,1,0,0));
    tbl.push_back(mk(1,0,0,1,0,8'h00, 1,0,0,8'h00,1,0,0));
    tbl.push_back(mk(1,0,0,0,1,8'h00, 1,0,0,8'h00,0,0,0));

    foreach (tbl[i]) begin
      enable = tbl[i].en; rx_done = tbl[i].done; rx_err = tbl[i].err;
      rd_en = tbl[i].rd; clr_status = tbl[i].clr; rx_data = tbl[i].data;
      cyc();
      chk($sformatf("tbl[%0d] rx_en", i), rx_en, tbl[i].x_en);
      chk($sformatf("tbl[%0d] rx_rst", i), rx_rst, tbl[i].x_rst);
      chk($sformatf("tbl[%0d] fifo_count", i), fifo_count, tbl[i].x_cnt);
      chk($sformatf("tbl[%0d] rd_data", i), rd_data, tbl[i].x_rd);
      chk($sformatf("tbl[%0d] fifo_full", i), fifo_full, int'(tbl[i].x_cnt == 4));
      chk($sformatf("tbl[%0d] fifo_empty", i), fifo_empty, int'(tbl[i].x_cnt == 0));
      chk($sformatf("tbl[%0d] overrun", i), overrun, tbl[i].x_ovr);
      chk($sformatf("tbl[%0d] frame_err", i), frame_err, tbl[i].x_fe);
      chk($sformatf("tbl[%0d] err_count", i), err_count, tbl[i].x_ec);
    end
    idle_in();

    // push and pop together while full
    frame(8'h11); frame(8'h22); frame(8'h33); frame(8'h44);
    chk("full4 count", fifo_count, 4);
    chk("full4 full", fifo_full, 1);
    rx_done = 1; rx_data = 8'h66; rd_en = 1; cyc();
    chk("pushpop count", fifo_count, 4);
    chk("pushpop overrun", overrun, 0);
    chk("pushpop head", rd_data, 8'h22);
    chk("pushpop rx_rst", rx_rst, 1);
    idle_in(); cyc();
    begin
      logic [7:0] exp_seq [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("drain[%0d]", k), rd_data, exp_seq[k]);
        rd_en = 1; cyc(); rd_en = 0;
      end
    end
    chk("drain empty", fifo_empty, 1);

    // error wins over done; saturation
    rx_done = 1; rx_err = 1; rx_data = 8'h77; cyc();
    chk("errdone count", fifo_count, 0);
    chk("errdone frame_err", frame_err, 1);
    chk("errdone err_count", err_count, 1);
    chk("errdone rx_rst", rx_rst, 1);
    idle_in(); cyc();
    for (int k = 0; k < 300; k++) begin
      rx_err = 1; cyc();
      rx_err = 0; cyc();
    end
    chk("sat err_count", err_count, 255);
    chk("sat fifo_count", fifo_count, 0);

    // clear coinciding with a new error
    clr_status = 1; rx_err = 1; cyc();
    chk("clr+err frame_err", frame_err, 1);
    chk("clr+err err_count", err_count, 1);
    rx_err = 0; cyc();
    chk("clr frame_err", frame_err, 0);
    chk("clr err_count", err_count, 0);
    clr_status = 0; cyc();

    // disable mid-frame
    frame(8'h5A);
    enable = 0; rx_busy = 1; rx_done = 1; rx_data = 8'h99; cyc();
    chk("dis rx_rst", rx_rst, 1);
    chk("dis rx_en", rx_en, 0);
    chk("dis ctrl_busy", ctrl_busy, 1);
    chk("dis count", fifo_count, 1);
    rx_done = 0; cyc();
    chk("dis2 rx_rst", rx_rst, 0);
    chk("dis2 rx_en", rx_en, 0);
    chk("dis2 ctrl_busy", ctrl_busy, 0);
    chk("dis2 count", fifo_count, 1);
    chk("dis2 head", rd_data, 8'h5A);

    // async reset with three bytes queued
    enable = 1; rx_busy = 0; cyc(); cyc();
    frame(8'h02); frame(8'h03);
    rx_err = 1; cyc(); rx_err = 0; cyc();
    chk("pre-rst count", fifo_count, 3);
    chk("pre-rst frame_err", frame_err, 1);
    rx_busy = 1; #1 arst_n = 0; #1;
    chk_reset_vals("async");
    enable = 0; idle_in();
    @(negedge clk); arst_n = 1; @(negedge clk);
    chk_reset_vals("post-async");

    // random traffic against the reference model
    m_armed = 0; m_clearing = 0; m_ovr = 0; m_fe = 0; m_ec = 0; m_q.delete();
    for (int n = 0; n < 4000; n++) begin
      bit en_r, done_r, err_r, rd_r, clr_r, full_b, push_b, drop_b, err_b;
      en_r   = ($urandom_range(0, 24) != 0);
      done_r = ($urandom_range(0, 2) == 0);
      err_r  = ($urandom_range(0, 9) == 0);
      rd_r   = ($urandom_range(0, 3) == 0);
      clr_r  = ($urandom_range(0, 29) == 0);
      enable = en_r; rx_done = done_r; rx_err = err_r; rd_en = rd_r; clr_status = clr_r;
      rx_busy = 1'($urandom); rx_data = 8'($urandom);

      full_b = (m_q.size() == 4);
      push_b = 0; drop_b = 0; err_b = 0;
      if (m_clearing) begin
        m_clearing = 0; m_armed = en_r;
      end else if (m_armed) begin
        if (!en_r || err_r || done_r) begin
          m_armed = 0; m_clearing = 1;
          if (en_r && err_r) err_b = 1;
          else if (en_r && done_r) begin
            if (!full_b || rd_r) push_b = 1; else drop_b = 1;
          end
        end
      end else if (en_r) m_clearing = 1;
      if (rd_r && m_q.size() > 0) void'(m_q.pop_front());
      if (push_b) m_q.push_back(rx_data);
      if (drop_b) m_ovr = 1; else if (clr_r) m_ovr = 0;
      if (err_b) begin
        m_fe = 1;
        m_ec = clr_r ? 1 : (m_ec < 255 ? m_ec + 1 : 255);
      end else if (clr_r) begin
        m_fe = 0; m_ec = 0;
      end

      cyc();
      chk("rnd rx_en", rx_en, m_armed);
      chk("rnd rx_rst", rx_rst, m_clearing);
      chk("rnd ctrl_busy", ctrl_busy, int'(m_armed || m_clearing));
      chk("rnd fifo_count", fifo_count, m_q.size());
      chk("rnd rd_data", rd_data, (m_q.size() > 0) ? int'(m_q[0]) : 0);
      chk("rnd fifo_full", fifo_full, int'(m_q.size() == 4));
      chk("rnd fifo_empty", fifo_empty, int'(m_q.size() == 0));
      chk("rnd overrun", overrun, m_ovr);
      chk("rnd frame_err", frame_err, m_fe);
      chk("rnd err_count", err_count, m_ec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences the UART receiver datapath on behalf of the APB register side. It arms the receiver, harvests each completed frame into a small show-ahead receive FIFO, and counts framing errors. After every frame it issues the receiver's synchronous clear, which the receiver needs because its done/err flags are sticky. The block sits between the APB register file and the receiver instance inside the UART top.

## Interface
Parameters:
- FIFO_DEPTH, 4 — receive FIFO entries; power of two, at least 2.
- ERR_CNT_W, 8 — width of the saturating framing-error counter.

Ports:
- clk  in  1  — system clock; the block uses this single clock.
- arst_n  in  1  — asynchronous, active-low reset.
- enable  in  1  — level; receive path enabled (from control register).
- clr_status  in  1  — one-cycle pulse; clears sticky flags and the error counter.
- rd_en  in  1  — one-cycle pulse; pop the FIFO head.
- rx_busy  in  1  — receiver busy.
- rx_done  in  1  — receiver sticky done.
- rx_err  in  1  — receiver sticky framing error.
- rx_data  in  8  — receiver parallel data.
- rx_en  out  1  — receiver enable.
- rx_rst  out  1  — receiver synchronous clear.
- rd_data  out  8  — FIFO head; 8'h00 when empty.
- fifo_empty  out  1  — FIFO empty.
- fifo_full  out  1  — FIFO full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  — number of occupied FIFO entries.
- overrun  out  1  — sticky; a byte was dropped because the FIFO was full.
- frame_err  out  1  — sticky; at least one framing error was seen.
- err_count  out  ERR_CNT_W  — saturating framing-error count.
- ctrl_busy  out  1  — high in every state except IDLE.

## Operation
The FSM has three states: IDLE, WAIT and CLEAR.

- **IDLE**
  - Outputs: rx_en=0, rx_rst=0.
  - Transition: when enable=1, go to CLEAR. This flushes any stale receiver state.
- **CLEAR**
  - Outputs: rx_rst=1, rx_en=0, for exactly one cycle.
  - Transition: go to WAIT if enable=1, otherwise go to IDLE.
- **WAIT**
  - Outputs: rx_en=1, rx_rst=0.
  - Priority order, evaluated every cycle:
    1. enable=0: go to CLEAR. Any frame in flight is aborted. Nothing is pushed or counted.
    2. rx_err=1: increment err_count (saturating at all-ones), set frame_err, go to CLEAR. If rx_done is also 1, the error wins and no byte is pushed.
    3. rx_done=1, and the FIFO is not full or rd_en=1 this cycle: push rx_data, go to CLEAR.
    4. rx_done=1 and FIFO full with no pop this cycle: drop the byte, set overrun, go to CLEAR.

FIFO:
- Synchronous, show-ahead.
- rd_en while empty is ignored and fifo_count is unchanged.
- A simultaneous push and pop leaves fifo_count unchanged. When full, the push succeeds and overrun is not set.
- Pointers wrap modulo FIFO_DEPTH.

Status:
- clr_status clears overrun, frame_err and err_count.
- If a new event occurs in the same cycle as clr_status, the event wins: the flag is set and err_count becomes 1.
- clr_status does not touch the FIFO contents.

## Timing
- Reset values:
  - state: IDLE
  - rx_en, rx_rst, overrun, frame_err, ctrl_busy: 0
  - err_count: 0
  - fifo_count: 0, fifo_empty=1, fifo_full=0
  - rd_data: 8'h00
- Latency, from the first cycle rx_done=1 is seen in WAIT:
  - Byte visible on rd_data, and fifo_count incremented, one cycle later.
  - rx_rst high in the next cycle (CLEAR).
  - rx_en back to 1 two cycles after detection.
- rx_rst is never high for more than one consecutive cycle.
- rx_en and rx_rst are never high in the same cycle.
- enable is sampled every cycle; deassertion takes effect on the next edge.
- Asserting arst_n low mid-frame immediately returns the block to the reset values above, including a flushed FIFO.
- All outputs are registered except:
  - rd_data (FIFO memory read at the head pointer, gated to 0 when empty)
  - fifo_empty and fifo_full (decoded from the count)

## Structure
- Shared package uart_pkg holds:
  - the state encoding constants IDLE=2'd0, WAIT=2'd1, CLEAR=2'd2
  - the default FIFO_DEPTH and ERR_CNT_W
- One sub-module, uart_rx_fifo: a parameterised synchronous FIFO with push, pop, show-ahead head, count, full and empty.
- The FSM, status flags and error counter live in uart_rx_ctrl.

## Test plan
1. **Reset, enable and single frame**
   - Stimulus: reset, raise enable; model the receiver returning rx_done=1 with rx_data=8'hA5.
   - Required: rx_rst pulses exactly once after enable; after the frame, rd_data=8'hA5, fifo_count=1, and one more rx_rst pulse occurs.
2. **Overrun with FIFO_DEPTH=4**
   - Stimulus: deliver frames 8'h01 through 8'h05 with no rd_en.
   - Required: after the fifth frame, fifo_full=1, fifo_count=4, overrun=1. Popping four times reads 01, 02, 03, 04, then fifo_empty=1 and rd_data=8'h00.
3. **Push and pop together when full**
   - Stimulus: FIFO full; rx_done and rd_en occur in the same cycle.
   - Required: fifo_count stays 4, overrun stays 0, and the new byte appears in order.
4. **Error priority and saturation**
   - Stimulus: rx_err and rx_done both asserted.
   - Required: no push, frame_err=1, err_count increments.
   - Stimulus: 300 error frames with ERR_CNT_W=8.
   - Required: err_count=255.
5. **Clear versus new event**
   - Stimulus: clr_status in the same cycle as a new rx_err.
   - Required: frame_err=1, err_count=1.
6. **Disable and asynchronous reset mid-frame**
   - Stimulus: drop enable while rx_busy=1.
   - Required: CLEAR for one cycle, then IDLE, rx_en=0, nothing pushed.
   - Stimulus: pulse arst_n low with FIFO count 3.
   - Required: all outputs return to their reset values.
